// File: rtl/view_param_ctrl.sv
// View parameter controller: stages physics updates, runs near/far repeat engine; VIEW_STATS_EN adds debug counters.
// Latency: outputs and frame_commit_out update one cycle after the commit event (hcount 0, vcount COMMIT_LINE).
// Backpressure: upd_ready_out drops only for the single COMMIT cycle; a second update before commit replaces the first.
module view_param_ctrl #(
  parameter int REPEAT_CYCLES = 100000,
  parameter int NEAR_INIT     = 0,
  parameter int FAR_INIT      = 17,
  parameter int MAG_MAX       = 255,
  parameter int COMMIT_LINE   = 720
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [3:0]  change_in,
  input  logic        upd_valid_in,
  output logic        upd_ready_out,
  input  logic [15:0] ballx_in,
  input  logic [15:0] bally_in,
  input  logic [15:0] angle_in,
  output logic [15:0] ballx_out,
  output logic [15:0] bally_out,
  output logic [15:0] angle_out,
  output logic [7:0]  near_mag_out,
  output logic [7:0]  far_mag_out,
  output logic        frame_commit_out,
  output logic [31:0] debug_out
);

  localparam int CW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REPEAT_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          commit_ev, accept;
  logic [15:0]   angle_norm;
  logic [15:0]   stg_x, stg_y, stg_a;
  logic [7:0]    far_mag, near_mag, far_nxt, near_nxt;
  logic [CW-1:0] far_cnt, near_cnt;
  logic          far_hold, near_hold, far_step, near_step;

  assign commit_ev  = (hcount_in == 11'd0) && (vcount_in == 10'(COMMIT_LINE));
  assign accept     = upd_valid_in && upd_ready_out;
  assign angle_norm = (angle_in >= 16'd360) ? angle_in - 16'd360 : angle_in;

  assign far_hold  = |change_in[1:0];
  assign near_hold = |change_in[3:2];
  assign far_step  = far_hold && (far_cnt == CNT_LAST);
  assign near_step = near_hold && (near_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, PENDING: begin
        if (commit_ev)   state_nxt = COMMIT;
        else if (accept) state_nxt = PENDING;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // far is resolved first so the near+ limit sees the post-step far value
  always_comb begin
    far_nxt = far_mag;
    if (far_step) begin
      if (change_in[0]) begin
        if (far_mag < 8'(MAG_MAX)) far_nxt = far_mag + 8'd1;
      end else if ({1'b0, far_mag} > ({1'b0, near_mag} + 9'd1)) begin
        far_nxt = far_mag - 8'd1;
      end
    end
    near_nxt = near_mag;
    if (near_step) begin
      if (change_in[2]) begin
        if (({1'b0, near_mag} + 9'd1) < {1'b0, far_nxt}) near_nxt = near_mag + 8'd1;
      end else if (near_mag != 8'd0) begin
        near_nxt = near_mag - 8'd1;
      end
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      upd_ready_out    <= 1'b0;
      stg_x            <= '0;
      stg_y            <= '0;
      stg_a            <= '0;
      far_mag          <= 8'(FAR_INIT);
      near_mag         <= 8'(NEAR_INIT);
      far_cnt          <= '0;
      near_cnt         <= '0;
      ballx_out        <= '0;
      bally_out        <= '0;
      angle_out        <= '0;
      near_mag_out     <= 8'(NEAR_INIT);
      far_mag_out      <= 8'(FAR_INIT);
      frame_commit_out <= 1'b0;
    end else begin
      state         <= state_nxt;
      upd_ready_out <= (state_nxt != COMMIT);
      if (accept) begin
        stg_x <= ballx_in;
        stg_y <= bally_in;
        stg_a <= angle_norm;
      end
      far_mag  <= far_nxt;
      near_mag <= near_nxt;
      far_cnt  <= (!far_hold || far_step) ? '0 : far_cnt + CW'(1);
      near_cnt <= (!near_hold || near_step) ? '0 : near_cnt + CW'(1);
      frame_commit_out <= (state_nxt == COMMIT);
      // an update accepted on the event cycle itself bypasses staging into this commit
      if (state_nxt == COMMIT) begin
        near_mag_out <= near_mag;
        far_mag_out  <= far_mag;
        if (accept) begin
          ballx_out <= ballx_in;
          bally_out <= bally_in;
          angle_out <= angle_norm;
        end else if (state == PENDING) begin
          ballx_out <= stg_x;
          bally_out <= stg_y;
          angle_out <= stg_a;
        end
      end
    end
  end

`ifdef VIEW_STATS_EN
  logic [15:0] commit_cnt, ovw_cnt;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      commit_cnt <= '0;
      ovw_cnt    <= '0;
    end else begin
      if (commit_ev) commit_cnt <= commit_cnt + 16'd1;
      if (accept && (state == PENDING) && (ovw_cnt != 16'hFFFF)) ovw_cnt <= ovw_cnt + 16'd1;
    end
  end

  assign debug_out = {commit_cnt, ovw_cnt};
`else
  assign debug_out = '0;
`endif

endmodule

// File: tb/tb_view_param_ctrl.sv
// Bench for view_param_ctrl: vector table, hand-written magnitude sequences and random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_view_param_ctrl;
  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [3:0]  change;
  logic        upd_valid, upd_ready;
  logic [15:0] ballx_i, bally_i, angle_i, ballx_o, bally_o, angle_o;
  logic [7:0]  near_o, far_o;
  logic        commit_o;
  logic [31:0] debug_o;

  always #5 clk = ~clk;

  view_param_ctrl #(.REPEAT_CYCLES(RC)) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .change_in(change), .upd_valid_in(upd_valid), .upd_ready_out(upd_ready),
    .ballx_in(ballx_i), .bally_in(bally_i), .angle_in(angle_i),
    .ballx_out(ballx_o), .bally_out(bally_o), .angle_out(angle_o),
    .near_mag_out(near_o), .far_mag_out(far_o), .frame_commit_out(commit_o),
    .debug_out(debug_o)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_x, m_y, m_a, s_x, s_y, s_a;
  int m_near, m_far, m_on, m_of;
  int fh_len, nh_len, m_ccnt, m_ovw;
  bit m_pend, m_commit, m_in_commit, m_fresh;

  typedef struct {
    logic        vld;
    logic [15:0] x, y, a;
    logic [10:0] h;
    logic [9:0]  v;
    logic [15:0] ex, ey, ea;
    logic        ecommit, erdy;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_a = 0; s_x = 0; s_y = 0; s_a = 0;
    m_near = 0; m_far = 17; m_on = 0; m_of = 17;
    fh_len = 0; nh_len = 0; m_ccnt = 0; m_ovw = 0;
    m_pend = 0; m_commit = 0; m_in_commit = 0; m_fresh = 1;
  endtask

  task automatic check_all();
    logic [31:0] exp_dbg;
`ifdef VIEW_STATS_EN
    exp_dbg = {m_ccnt[15:0], m_ovw[15:0]};
`else
    exp_dbg = 32'd0;
`endif
    check("ballx", 32'(ballx_o), m_x);
    check("bally", 32'(bally_o), m_y);
    check("angle", 32'(angle_o), m_a);
    check("near", 32'(near_o), m_on);
    check("far", 32'(far_o), m_of);
    check("commit", 32'(commit_o), 32'(m_commit));
    check("ready", 32'(upd_ready), 32'(!m_in_commit && !m_fresh));
    check("debug", debug_o, exp_dbg);
  endtask

  // one clock: evaluate the model on the inputs seen at the edge, then compare
  task automatic tick();
    bit rdy, acc, ev, fstep, nstep;
    int a_n, nf, nn;
    rdy = !m_in_commit && !m_fresh;
    acc = upd_valid && rdy;
    ev  = (hcount == 0) && (vcount == 720);
    a_n = (angle_i >= 360) ? int'(angle_i) - 360 : int'(angle_i);
    fh_len = (change[1:0] != 0) ? fh_len + 1 : 0;
    nh_len = (change[3:2] != 0) ? nh_len + 1 : 0;
    fstep = (fh_len != 0) && (fh_len % RC == 0);
    nstep = (nh_len != 0) && (nh_len % RC == 0);
    nf = m_far;
    if (fstep) begin
      if (change[0]) begin if (m_far < 255) nf = m_far + 1; end
      else if (m_far - 1 > m_near) nf = m_far - 1;
    end
    nn = m_near;
    if (nstep) begin
      if (change[2]) begin if (m_near + 1 < nf) nn = m_near + 1; end
      else if (m_near > 0) nn = m_near - 1;
    end
    if (ev) m_ccnt = (m_ccnt + 1) % 65536;
    if (acc && m_pend && m_ovw < 65535) m_ovw++;
    if (ev && !m_in_commit) begin
      m_on = m_near; m_of = m_far;
      if (acc) begin m_x = ballx_i; m_y = bally_i; m_a = a_n; end
      else if (m_pend) begin m_x = s_x; m_y = s_y; m_a = s_a; end
      m_pend = 0; m_commit = 1; m_in_commit = 1;
    end else begin
      m_commit = 0; m_in_commit = 0;
      if (acc) begin s_x = ballx_i; s_y = bally_i; s_a = a_n; m_pend = 1; end
    end
    m_fresh = 0; m_near = nn; m_far = nf;
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #2 check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic hold(input logic [3:0] c, input int n);
    upd_valid = 1'b0; hcount = 11'd100; vcount = 10'd100; change = c;
    repeat (n) tick();
    change = 4'd0;
  endtask

  task automatic commit_now();
    upd_valid = 1'b0; change = 4'd0;
    hcount = 11'd0; vcount = 10'd720;
    tick();
    hcount = 11'd100; vcount = 10'd100;
    tick();
  endtask

  initial begin
    int hold_left;
    tbl[0]  = '{1'b0, 16'd0,   16'd0,  16'd0,   11'd5, 10'd300, 16'd0,   16'd0,  16'd0,   1'b0, 1'b1};
    tbl[1]  = '{1'b1, 16'd100, 16'd50, 16'd400, 11'd6, 10'd300, 16'd0,   16'd0,  16'd0,   1'b0, 1'b1};
    tbl[2]  = '{1'b0, 16'd0,   16'd0,  16'd0,   11'd7, 10'd300, 16'd0,   16'd0,  16'd0,   1'b0, 1'b1};
    tbl[3]  = '{1'b0, 16'd0,   16'd0,  16'd0,   11'd0, 10'd720, 16'd100, 16'd50, 16'd40,  1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'd0,   16'd0,  16'd0,   11'd0, 10'd721, 16'd100, 16'd50, 16'd40,  1'b0, 1'b1};
    tbl[5]  = '{1'b1, 16'd5,   16'd1,  16'd10,  11'd3, 10'd10,  16'd100, 16'd50, 16'd40,  1'b0, 1'b1};
    tbl[6]  = '{1'b1, 16'd9,   16'd2,  16'd719, 11'd4, 10'd10,  16'd100, 16'd50, 16'd40,  1'b0, 1'b1};
    tbl[7]  = '{1'b0, 16'd0,   16'd0,  16'd0,   11'd0, 10'd720, 16'd9,   16'd2,  16'd359, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 16'd0,   16'd0,  16'd0,   11'd1, 10'd720, 16'd9,   16'd2,  16'd359, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 16'd0,   16'd0,  16'd0,   11'd0, 10'd720, 16'd9,   16'd2,  16'd359, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 16'd0,   16'd0,  16'd0,   11'd9, 10'd100, 16'd9,   16'd2,  16'd359, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 16'd77,  16'd3,  16'd360, 11'd0, 10'd720, 16'd77,  16'd3,  16'd0,   1'b1, 1'b0};
    tbl[12] = '{1'b1, 16'd11,  16'd11, 16'd11,  11'd1, 10'd720, 16'd77,  16'd3,  16'd0,   1'b0, 1'b1};
    tbl[13] = '{1'b0, 16'd0,   16'd0,  16'd0,   11'd0, 10'd720, 16'd77,  16'd3,  16'd0,   1'b1, 1'b0};

    rst_n = 1'b0; hcount = 11'd100; vcount = 10'd100; change = 4'd0;
    upd_valid = 1'b0; ballx_i = '0; bally_i = '0; angle_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("rst_ready", 32'(upd_ready), 32'd0);
    check("rst_far", 32'(far_o), 32'd17);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(upd_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      upd_valid = tbl[i].vld; ballx_i = tbl[i].x; bally_i = tbl[i].y; angle_i = tbl[i].a;
      hcount = tbl[i].h; vcount = tbl[i].v; change = 4'd0;
      tick();
      check("tbl_x", 32'(ballx_o), 32'(tbl[i].ex));
      check("tbl_y", 32'(bally_o), 32'(tbl[i].ey));
      check("tbl_angle", 32'(angle_o), 32'(tbl[i].ea));
      check("tbl_commit", 32'(commit_o), 32'(tbl[i].ecommit));
      check("tbl_ready", 32'(upd_ready), 32'(tbl[i].erdy));
      check("tbl_far", 32'(far_o), 32'd17);
    end
`ifdef VIEW_STATS_EN
    check("tbl_debug", debug_o, {16'd5, 16'd1});
`else
    check("tbl_debug", debug_o, 32'd0);
`endif

    hold(4'b0001, 12);
    check("far_before_commit", 32'(far_o), 32'd17);
    commit_now();
    check("far_up3", 32'(far_o), 32'd20);
    hold(4'b0100, 72);
    hold(4'b0010, 12);
    commit_now();
    check("far_floor_far", 32'(far_o), 32'd19);
    check("far_floor_near", 32'(near_o), 32'd18);
    hold(4'b1000, 32);
    hold(4'b0010, 28);
    commit_now();
    check("setup_near", 32'(near_o), 32'd10);
    check("setup_far", 32'(far_o), 32'd12);
    hold(4'b0110, 4);
    commit_now();
    check("simul_far", 32'(far_o), 32'd11);
    check("simul_near", 32'(near_o), 32'd10);
    hold(4'b0011, 4);
    hold(4'b1100, 4);
    commit_now();
    check("prio_far", 32'(far_o), 32'd12);
    check("prio_near", 32'(near_o), 32'd11);
    hold(4'b0001, 3);
    hold(4'b0000, 1);
    hold(4'b0001, 3);
    commit_now();
    check("release_clears", 32'(far_o), 32'd12);
    hold(4'b0001, 4 * 250);
    commit_now();
    check("far_max", 32'(far_o), 32'd255);
    hold(4'b1000, 4 * 20);
    commit_now();
    check("near_min", 32'(near_o), 32'd0);

    upd_valid = 1'b1; ballx_i = 16'd1234; bally_i = 16'd99; angle_i = 16'd5;
    hcount = 11'd100; vcount = 10'd100;
    tick();
    upd_valid = 1'b0;
    do_reset();
    tick();
    commit_now();
    check("rst_drop_x", 32'(ballx_o), 32'd0);
    check("rst_drop_y", 32'(bally_o), 32'd0);
    check("rst_drop_angle", 32'(angle_o), 32'd0);
    check("rst_drop_near", 32'(near_o), 32'd0);
    check("rst_drop_far", 32'(far_o), 32'd17);

    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        change = 4'($urandom_range(0, 15));
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
      upd_valid = ($urandom_range(0, 3) == 0);
      ballx_i = 16'($urandom);
      bally_i = 16'($urandom);
      angle_i = 16'($urandom_range(0, 719));
      if (i % 40 == 39) begin
        hcount = 11'd0; vcount = 10'd720;
      end else begin
        hcount = 11'($urandom_range(1, 2047));
        vcount = 10'($urandom_range(0, 719));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
